// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default frame width for the SPI slave.
package spi_pkg;
   localparam int DATA_W_DEF = 8;
   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses on the synchronized level.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);
   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end
   assign rise_o = sync_q[STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave sampling mosi on sclk fall, shifting miso on sclk rise, with a
// one-deep transmit holding register and pulse status outputs.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              sclk_i,
   input  logic              cs_n_i,
   input  logic              mosi_i,
   output logic              miso_o,
   output logic              miso_oe_o,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              underrun_o,
   output logic              abort_o,
   output logic              busy_o
);
   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
   state_e            state_q, state_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, hold_q, hold_d, rx_data_q, rx_data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              full_q, full_d, pend_q, pend_d, rx_valid_q, underrun_q, underrun_d, abort_q, abort_d;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic              sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s, load, wr;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk_i(clk_i), .reset_i(reset_i), .d_i(sclk_i), .rise_o(sclk_rise), .fall_o(sclk_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .clk_i(clk_i), .reset_i(reset_i), .d_i(cs_n_i), .rise_o(cs_rise), .fall_o(cs_fall));

   assign mosi_s = mosi_q[SYNC_STAGES-1];
   assign wr     = tx_valid_i && !full_q;

   always_comb begin
      state_d    = state_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      cnt_d      = cnt_q;
      rx_data_d  = rx_data_q;
      pend_d     = 1'b0;
      underrun_d = 1'b0;
      abort_d    = 1'b0;
      load       = 1'b0;
      case (state_q)
         IDLE: if (cs_fall) begin
            state_d    = SHIFT;
            load       = 1'b1;
            tx_sh_d    = full_q ? hold_q : '0;
            underrun_d = !full_q;
            cnt_d      = '0;
         end
         SHIFT: if (cs_rise) begin
            state_d = IDLE;
            abort_d = 1'b1;
         end else if (sclk_fall) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_s};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               rx_data_d = rx_sh_d;
               pend_d    = 1'b1;
               state_d   = WAIT_CS;
            end
         end else if (sclk_rise && cnt_q != '0) begin
            tx_sh_d = tx_sh_q << 1;
         end
         WAIT_CS: if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // a write landing on the load cycle saw an empty register, so it is kept for the next frame
      full_d = wr ? 1'b1 : (load ? 1'b0 : full_q);
      hold_d = wr ? tx_data_i : hold_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         cnt_q      <= '0;
         hold_q     <= '0;
         full_q     <= 1'b0;
         rx_data_q  <= '0;
         pend_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         abort_q    <= 1'b0;
         mosi_q     <= '0;
      end else begin
         state_q    <= state_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         full_q     <= full_d;
         rx_data_q  <= rx_data_d;
         pend_q     <= pend_d;
         rx_valid_q <= pend_q;
         underrun_q <= underrun_d;
         abort_q    <= abort_d;
         mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      end
   end

   // selected means entered on cs fall and not yet seen cs rise
   assign miso_oe_o  = (state_q != IDLE) && !cs_rise;
   assign miso_o     = miso_oe_o && state_q == SHIFT && tx_sh_q[DATA_W-1];
   assign busy_o     = state_q != IDLE;
   assign tx_ready_o = !full_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign underrun_o = underrun_q;
   assign abort_o    = abort_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives SPI frames as a master and checks against a queue-based transmit model.
module tb_spi_slave;
   localparam int W = 8, S = 2, H = 10;
   logic clk = 1'b0, reset, sclk, cs_n, mosi, tx_valid;
   logic [W-1:0] tx_data, rx_data;
   logic miso, miso_oe, tx_ready, rx_valid, underrun, abort, busy;
   int n_tests = 0, n_fail = 0;
   int cyc = 0, fall_cyc = 0, lat = 0, rxv_cnt = 0, ab_cnt = 0, ur_cnt = 0, oe_viol = 0, oe_low = 0;
   logic [W-1:0] rx_last = '0;
   logic [W-1:0] txq[$];

   spi_slave #(.DATA_W(W), .SYNC_STAGES(S)) dut (
      .clk_i(clk), .reset_i(reset), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
      .miso_o(miso), .miso_oe_o(miso_oe), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
      .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
      .underrun_o(underrun), .abort_o(abort), .busy_o(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_cnt++;
         rx_last = rx_data;
         lat = cyc - fall_cyc;
      end
      if (abort) ab_cnt++;
      if (underrun) ur_cnt++;
      if (!miso_oe && miso !== 1'b0) oe_viol++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_write(input logic [W-1:0] b);
      int t = 0;
      while (tx_ready !== 1'b1 && t < 100) begin wait_cyc(1); t++; end
      n_tests++;
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_wait: tx_ready=%b required 1", tx_ready); end
      tx_valid = 1'b1; tx_data = b;
      wait_cyc(1);
      tx_valid = 1'b0;
      txq.push_back(b);
   endtask

   // master: drive on sclk rise, sample miso on sclk fall; returns expected miso byte from model
   task automatic frame(input logic [W-1:0] mo, input int nbits, input bit raise,
                        output logic [W-1:0] mi, output logic [W-1:0] exp_mi);
      exp_mi = txq.size() > 0 ? txq.pop_front() : '0;
      mi = '0;
      cs_n = 1'b0;
      wait_cyc(H);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1; mosi = mo[W-1-i];
         wait_cyc(H);
         mi = {mi[W-2:0], miso};
         if (miso_oe !== 1'b1) oe_low++;
         sclk = 1'b0; fall_cyc = cyc;
         wait_cyc(H);
      end
      if (raise) begin cs_n = 1'b1; wait_cyc(H); end
   endtask

   task automatic chk_full(input string nm, input logic [W-1:0] mo, input logic [W-1:0] mi,
                           input logic [W-1:0] exp_mi, input int rxv0);
      n_tests++;
      if (rx_last !== mo || rxv_cnt != rxv0 + 1) begin
         n_fail++; $display("FAIL %s_rx: rx=%h pulses=%0d required rx=%h pulses=%0d", nm, rx_last, rxv_cnt - rxv0, mo, 1);
      end
      n_tests++;
      if (mi !== exp_mi) begin n_fail++; $display("FAIL %s_miso: got %h required %h", nm, mi, exp_mi); end
   endtask

   task automatic test_reset;
      n_tests++;
      if ({miso, miso_oe, rx_data, rx_valid, underrun, abort, busy, tx_ready} !== {2'b00, 8'h00, 4'b0000, 1'b1}) begin
         n_fail++; $display("FAIL reset_outputs: got %b required %b", {miso, miso_oe, rx_data, rx_valid, underrun, abort, busy, tx_ready}, 15'b1);
      end
      reset = 1'b0;
      wait_cyc(S + 3);
   endtask

   task automatic test_basic;
      logic [W-1:0] mi, em;
      int rxv0 = rxv_cnt, ur0 = ur_cnt;
      tx_write(8'hA5);
      n_tests++;
      if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_low: tx_ready=%b required 0", tx_ready); end
      frame(8'h3C, W, 1, mi, em);
      chk_full("basic", 8'h3C, mi, em, rxv0);
      n_tests++;
      if (em !== 8'hA5 || ur_cnt != ur0) begin n_fail++; $display("FAIL basic_model: miso byte %h underruns %0d required A5 and 0", em, ur_cnt - ur0); end
      n_tests++;
      if (lat != S + 2) begin n_fail++; $display("FAIL latency: got %0d required %0d", lat, S + 2); end
      n_tests++;
      if (busy !== 1'b0 || tx_ready !== 1'b1 || oe_low != 0) begin
         n_fail++; $display("FAIL basic_idle: busy=%b tx_ready=%b oe_low=%0d required 0 1 0", busy, tx_ready, oe_low);
      end
   endtask

   task automatic test_underrun;
      logic [W-1:0] mi, em;
      int rxv0 = rxv_cnt, ur0 = ur_cnt;
      frame(8'hC3, W, 1, mi, em);
      chk_full("underrun", 8'hC3, mi, em, rxv0);
      n_tests++;
      if (ur_cnt != ur0 + 1 || mi !== 8'h00) begin n_fail++; $display("FAIL underrun_pulse: pulses=%0d miso=%h required 1 and 00", ur_cnt - ur0, mi); end
   endtask

   task automatic test_abort;
      logic [W-1:0] mi, em, prev;
      int rxv0 = rxv_cnt, ab0 = ab_cnt;
      prev = rx_last;
      tx_write(8'h5A);
      frame(8'hFF, 5, 1, mi, em);
      n_tests++;
      if (ab_cnt != ab0 + 1 || rxv_cnt != rxv0) begin n_fail++; $display("FAIL abort_pulse: abort=%0d rx_valid=%0d required 1 and 0", ab_cnt - ab0, rxv_cnt - rxv0); end
      n_tests++;
      if (rx_data !== prev) begin n_fail++; $display("FAIL abort_rx_hold: rx_data=%h required %h", rx_data, prev); end
      n_tests++;
      if (mi[4:0] !== em[7:3]) begin n_fail++; $display("FAIL abort_miso: got %h required %h", mi[4:0], em[7:3]); end
      rxv0 = rxv_cnt;
      tx_write(8'h42);
      frame(8'h81, W, 1, mi, em);
      chk_full("after_abort", 8'h81, mi, em, rxv0);
   endtask

   task automatic test_same_cycle;
      logic [W-1:0] mi, em, mi2, em2;
      int rxv0 = rxv_cnt, ur0 = ur_cnt;
      fork
         frame(8'h6E, W, 1, mi, em);
         begin
            wait_cyc(S);
            tx_valid = 1'b1; tx_data = 8'hD7;
            wait_cyc(1);
            tx_valid = 1'b0;
            txq.push_back(8'hD7);
         end
      join
      chk_full("same_cycle", 8'h6E, mi, em, rxv0);
      n_tests++;
      if (ur_cnt != ur0 + 1) begin n_fail++; $display("FAIL same_cycle_underrun: pulses=%0d required 1", ur_cnt - ur0); end
      rxv0 = rxv_cnt;
      frame(8'h19, W, 1, mi2, em2);
      chk_full("same_cycle_next", 8'h19, mi2, em2, rxv0);
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] mi, em;
      int rxv0 = rxv_cnt;
      tx_write(8'h55);
      fork
         frame(8'h12, W, 1, mi, em);
         begin wait_cyc(3 * H); tx_write(8'hAA); end
      join
      chk_full("b2b_first", 8'h12, mi, em, rxv0);
      rxv0 = rxv_cnt;
      frame(8'h34, W, 1, mi, em);
      chk_full("b2b_second", 8'h34, mi, em, rxv0);
      n_tests++;
      if (mi !== 8'hAA) begin n_fail++; $display("FAIL b2b_order: second miso %h required AA", mi); end
   endtask

   task automatic test_mid_reset;
      logic [W-1:0] mi, em;
      int rxv0 = rxv_cnt, ur0 = ur_cnt, ab0 = ab_cnt;
      tx_write(8'h77);
      fork
         frame(8'hE1, 4, 0, mi, em);
         begin wait_cyc(2 * H); tx_write(8'h99); end
      join
      reset = 1'b1; cs_n = 1'b1; sclk = 1'b0;
      wait_cyc(1);
      n_tests++;
      if ({miso, miso_oe, rx_data, rx_valid, underrun, abort, busy, tx_ready} !== {2'b00, 8'h00, 4'b0000, 1'b1}) begin
         n_fail++; $display("FAIL midreset_outputs: got %b required %b", {miso, miso_oe, rx_data, rx_valid, underrun, abort, busy, tx_ready}, 15'b1);
      end
      wait_cyc(2);
      reset = 1'b0;
      txq.delete();
      wait_cyc(S + 3);
      n_tests++;
      if (rxv_cnt != rxv0 || ur_cnt != ur0 || ab_cnt != ab0) begin
         n_fail++; $display("FAIL midreset_pulses: rx_valid=%0d underrun=%0d abort=%0d required 0 0 0", rxv_cnt - rxv0, ur_cnt - ur0, ab_cnt - ab0);
      end
      frame(8'hF0, W, 1, mi, em);
      chk_full("after_reset", 8'hF0, mi, em, rxv0);
      n_tests++;
      if (ur_cnt != ur0 + 1) begin n_fail++; $display("FAIL midreset_hold_discard: underruns %0d required 1", ur_cnt - ur0); end
   endtask

   task automatic test_random;
      logic [W-1:0] mo, mi, em;
      int rxv0, ur0, exp_ur;
      for (int k = 0; k < 8; k++) begin
         mo = W'($urandom);
         if ($urandom_range(0, 1) == 1) tx_write(W'($urandom));
         exp_ur = txq.size() == 0 ? 1 : 0;
         rxv0 = rxv_cnt; ur0 = ur_cnt;
         frame(mo, W, 1, mi, em);
         chk_full("random", mo, mi, em, rxv0);
         n_tests++;
         if (ur_cnt - ur0 != exp_ur) begin n_fail++; $display("FAIL random_underrun: got %0d required %0d", ur_cnt - ur0, exp_ur); end
      end
      n_tests++;
      if (oe_viol != 0 || oe_low != 0) begin n_fail++; $display("FAIL miso_oe_rule: viol=%0d low=%0d required 0 0", oe_viol, oe_low); end
   endtask

   initial begin
      reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      wait_cyc(3);
      test_reset;
      test_basic;
      test_underrun;
      test_abort;
      test_same_cycle;
      test_back_to_back;
      test_mid_reset;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
